// File: rtl/xor_arbiter_puf_pkg.sv
// xor_arbiter_puf_pkg
//   Shared types and sizing helpers for the XOR arbiter PUF evaluator.
//   - state_t         : evaluation sequencer states
//   - vw_f()          : counter width able to hold the value VOTES
//   - vote_cycles_f() : clock cycles spent per evaluation (ARM + LAUNCH + SAMPLE)
package xor_arbiter_puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int vw_f(input int votes);
        return $clog2(votes + 1);
    endfunction

    // ARM (settle) + LAUNCH (settle + 2 synchronizer flops) + one SAMPLE cycle
    function automatic int vote_cycles_f(input int settle);
        return 2 * settle + 3;
    endfunction

endpackage

// File: rtl/arbiter_chain.sv
// arbiter_chain
//   One N-stage arbiter switch chain. Both rails start from the same race
//   edge; each stage either passes the rails straight or crosses them
//   according to its challenge bit. The response latch captures rail 0 on
//   the rising edge of rail 1, i.e. it records which rail won the race.
//   Ports:
//     race_i      - race launch edge (from the clk_i domain sequencer)
//     challenge_i - per-stage straight/cross selects, held stable by the caller
//     resp_o      - latched race winner, asynchronous to any system clock
module arbiter_chain #(
    parameter int N = 64
) (
    input  logic         race_i,
    input  logic [N-1:0] challenge_i,
    output logic         resp_o
);

    logic rail0;
    logic rail1;
    logic resp_q;

    // Functionally both rails carry race_i; the winner is decided purely by
    // physical path delay through the crossed/straight switch sequence.
    always_comb begin
        logic t;
        logic b;
        logic tmp;
        t   = race_i;
        b   = race_i;
        tmp = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (challenge_i[i]) begin
                tmp = t;
                t   = b;
                b   = tmp;
            end
        end
        rail0 = t;
        rail1 = b;
    end

    // Arbiter latch: the only storage in the block not clocked by clk_i.
    always_ff @(posedge rail1) begin
        resp_q <= rail0;
    end

    assign resp_o = resp_q;

endmodule

// File: rtl/xor_arbiter_puf_eval.sv
// xor_arbiter_puf_eval
//   K parallel arbiter chains driven by an on-chip race sequencer. Each
//   challenge is evaluated VOTES times; the XOR of the chain outputs and each
//   chain output are majority-voted, and the response is flagged stable when
//   every XOR sample agreed.
//   Ports:
//     clk_i, rst_i   - clock, synchronous active-high reset
//     req_valid_i    - challenge valid (accepted only in IDLE)
//     req_ready_o    - high in IDLE
//     challenge_i    - K*N challenge, bits [k*N +: N] feed chain k
//     resp_valid_o   - response held in DONE until resp_ready_i
//     resp_ready_i   - consumer accepts the response
//     response_o     - majority of per-evaluation XOR samples
//     chain_resp_o   - per-chain majority
//     stable_o       - all XOR samples equal
//     busy_o         - evaluation in progress (not IDLE, not DONE)
module xor_arbiter_puf_eval
    import xor_arbiter_puf_pkg::*;
#(
    parameter int N             = 64,
    parameter int K             = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int VOTES         = 7
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           req_valid_i,
    output logic           req_ready_o,
    input  logic [K*N-1:0] challenge_i,
    output logic           resp_valid_o,
    input  logic           resp_ready_i,
    output logic           response_o,
    output logic [K-1:0]   chain_resp_o,
    output logic           stable_o,
    output logic           busy_o
);

    if (N < 2) begin : g_bad_n
        $error("xor_arbiter_puf_eval: N must be at least 2");
    end
    if (K < 1) begin : g_bad_k
        $error("xor_arbiter_puf_eval: K must be at least 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("xor_arbiter_puf_eval: SETTLE_CYCLES must be at least 1");
    end
    if (VOTES < 1 || (VOTES % 2) == 0) begin : g_bad_votes
        $error("xor_arbiter_puf_eval: VOTES must be odd and at least 1");
    end

    localparam int VW = vw_f(VOTES);
    localparam int CW = $clog2(SETTLE_CYCLES + 3);

    localparam logic [VW-1:0] HALF        = VW'(VOTES / 2);
    localparam logic [VW-1:0] VMAX        = VW'(VOTES);
    localparam logic [CW-1:0] ARM_LAST    = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LAUNCH_LAST = CW'(SETTLE_CYCLES + 1);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [K*N-1:0]         chal_q, chal_d;
    logic                   race_q, race_d;
    logic [K-1:0]           chain_raw;
    logic [K-1:0]           sync1_q, sync1_d;
    logic [K-1:0]           sync2_q, sync2_d;
    logic [K-1:0][VW-1:0]   ones_q, ones_d;
    logic [VW-1:0]          xor_q, xor_d;
    logic [VW-1:0]          vote_q, vote_d;
    logic                   resp_q, resp_d;
    logic [K-1:0]           chain_resp_q, chain_resp_d;
    logic                   stable_q, stable_d;

    for (genvar k = 0; k < K; k++) begin : g_chain
        arbiter_chain #(.N(N)) u_chain (
            .race_i      (race_q),
            .challenge_i (chal_q[k*N +: N]),
            .resp_o      (chain_raw[k])
        );
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        chal_d       = chal_q;
        ones_d       = ones_q;
        xor_d        = xor_q;
        vote_d       = vote_q;
        resp_d       = resp_q;
        chain_resp_d = chain_resp_q;
        stable_d     = stable_q;
        // Latched chain outputs are asynchronous to clk_i.
        sync1_d      = chain_raw;
        sync2_d      = sync1_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    chal_d  = challenge_i;
                    ones_d  = '0;
                    xor_d   = '0;
                    vote_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (cnt_q == ARM_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LAUNCH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LAUNCH: begin
                if (cnt_q == LAUNCH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SAMPLE: begin
                for (int k = 0; k < K; k++) begin
                    ones_d[k] = ones_q[k] + VW'(sync2_q[k]);
                end
                xor_d  = xor_q + VW'(^sync2_q);
                vote_d = vote_q + VW'(1);
                if (vote_d == VMAX) begin
                    // Results are taken from the post-sample counts so they
                    // land on the same edge that enters DONE.
                    resp_d = (xor_d > HALF);
                    for (int k = 0; k < K; k++) begin
                        chain_resp_d[k] = (ones_d[k] > HALF);
                    end
                    stable_d = (xor_d == '0) || (xor_d == VMAX);
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_DONE: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so the race edge is a clean flop output, not a decode.
        race_d = (state_d == ST_LAUNCH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            chal_q       <= '0;
            race_q       <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            ones_q       <= '0;
            xor_q        <= '0;
            vote_q       <= '0;
            resp_q       <= 1'b0;
            chain_resp_q <= '0;
            stable_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            chal_q       <= chal_d;
            race_q       <= race_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            ones_q       <= ones_d;
            xor_q        <= xor_d;
            vote_q       <= vote_d;
            resp_q       <= resp_d;
            chain_resp_q <= chain_resp_d;
            stable_q     <= stable_d;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_DONE);
    assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign response_o   = resp_q;
    assign chain_resp_o = chain_resp_q;
    assign stable_o     = stable_q;

endmodule

// File: tb/tb_xor_arbiter_puf_eval.sv
// Bench for xor_arbiter_puf_eval (N=8, K=2, SETTLE_CYCLES=2, VOTES=3).
// Chain outputs are forced per vote; expected results come from counting
// the forced samples directly.
module tb_xor_arbiter_puf_eval;

    localparam int N   = 8;
    localparam int K   = 2;
    localparam int S   = 2;
    localparam int V   = 3;
    localparam int VPC = 2 * S + 3;
    localparam int LAT = V * VPC;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           req_valid_i = 1'b0;
    logic           req_ready_o;
    logic [K*N-1:0] challenge_i = '0;
    logic           resp_valid_o;
    logic           resp_ready_i = 1'b0;
    logic           response_o;
    logic [K-1:0]   chain_resp_o;
    logic           stable_o;
    logic           busy_o;

    xor_arbiter_puf_eval #(.N(N), .K(K), .SETTLE_CYCLES(S), .VOTES(V)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .challenge_i  (challenge_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .response_o   (response_o),
        .chain_resp_o (chain_resp_o),
        .stable_o     (stable_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [K-1:0]   pat [V];
    logic [K-1:0]   force_val;
    logic           exp_on = 1'b0;
    logic           exp_resp;
    logic [K-1:0]   exp_chain;
    logic           exp_stable;
    logic [K*N-1:0] exp_chal;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic set_chains(input logic [K-1:0] v);
        force_val = v;
        force dut.chain_raw = force_val;
    endtask

    // Reference: count ones per chain and XOR samples over the forced votes.
    task automatic model(output logic r, output logic [K-1:0] c, output logic s);
        int xc;
        int oc;
        xc = 0;
        for (int v = 0; v < V; v++) xc += int'(^pat[v]);
        for (int k = 0; k < K; k++) begin
            oc = 0;
            for (int v = 0; v < V; v++) oc += int'(pat[v][k]);
            c[k] = (oc > V / 2);
        end
        r = (xc > V / 2);
        s = (xc == 0) || (xc == V);
    endtask

    // Whenever a response is presented it must match the model and block
    // new requests.
    always @(negedge clk_i) begin
        if (!rst_i && resp_valid_o) begin
            chk("valid_when_expected", {31'b0, exp_on}, 32'd1);
            chk("response", {31'b0, response_o}, {31'b0, exp_resp});
            chk("chain_resp", {30'b0, chain_resp_o}, {30'b0, exp_chain});
            chk("stable", {31'b0, stable_o}, {31'b0, exp_stable});
            chk("ready_in_done", {31'b0, req_ready_o}, 32'd0);
            chk("busy_in_done", {31'b0, busy_o}, 32'd0);
        end
    end

    // hold: cycles of backpressure after valid; early: ready high from start;
    // wiggle: scramble challenge_i / req_valid_i during eval; abort_at: >0
    // asserts reset after that many edges.
    task automatic run_txn(input int hold, input bit early, input bit wiggle, input int abort_at);
        int lat;
        bit got;
        model(exp_resp, exp_chain, exp_stable);
        @(negedge clk_i);
        chk("ready_before_req", {31'b0, req_ready_o}, 32'd1);
        challenge_i  = {$urandom, $urandom};
        exp_chal     = challenge_i;
        req_valid_i  = 1'b1;
        resp_ready_i = early;
        exp_on       = 1'b1;
        set_chains(pat[0]);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
            if (abort_at > 0 && lat == abort_at) begin
                req_valid_i = 1'b0;
                rst_i = 1'b1;
                @(posedge clk_i);
                #1;
                chk("abort_ready", {31'b0, req_ready_o}, 32'd1);
                chk("abort_valid", {31'b0, resp_valid_o}, 32'd0);
                chk("abort_busy", {31'b0, busy_o}, 32'd0);
                chk("abort_race", {31'b0, dut.race_q}, 32'd0);
                rst_i  = 1'b0;
                exp_on = 1'b0;
                resp_ready_i = 1'b0;
                return;
            end
            if (resp_valid_o) begin
                got = 1'b1;
                req_valid_i = 1'b0;
            end else begin
                chk("busy_during_eval", {31'b0, busy_o}, 32'd1);
                chk("ready_during_eval", {31'b0, req_ready_o}, 32'd0);
                if (lat % VPC == 0 && lat / VPC < V) set_chains(pat[lat / VPC]);
                if (wiggle) begin
                    chk("chal_held", dut.chal_q[31:0], exp_chal[31:0]);
                    challenge_i = {$urandom, $urandom};
                    req_valid_i = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!got) begin
            chk("timeout", 32'd1, 32'd0);
            exp_on = 1'b0;
            return;
        end
        chk("latency", lat, LAT);
        if (!early) begin
            repeat (hold) @(posedge clk_i);
            @(negedge clk_i);
            resp_ready_i = 1'b1;
        end
        @(posedge clk_i);
        #1;
        chk("idle_after_accept", {31'b0, req_ready_o}, 32'd1);
        chk("valid_dropped", {31'b0, resp_valid_o}, 32'd0);
        resp_ready_i = 1'b0;
        exp_on = 1'b0;
    endtask

    initial begin
        set_chains('0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
        chk("rst_valid", {31'b0, resp_valid_o}, 32'd0);
        chk("rst_response", {31'b0, response_o}, 32'd0);
        chk("rst_chain", {30'b0, chain_resp_o}, 32'd0);
        chk("rst_stable", {31'b0, stable_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        rst_i = 1'b0;
        repeat (20) begin
            @(negedge clk_i);
            chk("idle_race", {31'b0, dut.race_q}, 32'd0);
            chk("idle_busy", {31'b0, busy_o}, 32'd0);
            chk("idle_ready", {31'b0, req_ready_o}, 32'd1);
        end

        // chain0=1, chain1=0 every vote
        pat[0] = 2'b01; pat[1] = 2'b01; pat[2] = 2'b01;
        run_txn(0, 1'b0, 1'b0, 0);
        model(exp_resp, exp_chain, exp_stable);
        chk("model_pin1", {29'b0, exp_resp, exp_chain, exp_stable}, {29'b0, 1'b1, 2'b01, 1'b1});
        chk("dut_pin1", {29'b0, response_o, chain_resp_o, stable_o}, {29'b0, 1'b1, 2'b01, 1'b1});

        // chain0 1,0,1 / chain1 0,0,1 -> XOR 1,0,0
        pat[0] = 2'b01; pat[1] = 2'b00; pat[2] = 2'b11;
        run_txn(0, 1'b0, 1'b0, 0);
        model(exp_resp, exp_chain, exp_stable);
        chk("model_pin2", {29'b0, exp_resp, exp_chain, exp_stable}, {29'b0, 1'b0, 2'b01, 1'b0});
        chk("dut_pin2", {29'b0, response_o, chain_resp_o, stable_o}, {29'b0, 1'b0, 2'b01, 1'b0});

        // backpressure for 10 cycles
        pat[0] = 2'b10; pat[1] = 2'b11; pat[2] = 2'b10;
        run_txn(10, 1'b0, 1'b0, 0);

        // reset during second LAUNCH, then a fresh full evaluation
        pat[0] = 2'b11; pat[1] = 2'b11; pat[2] = 2'b11;
        run_txn(0, 1'b0, 1'b0, VPC + S + 1);
        repeat (3) begin
            @(negedge clk_i);
            chk("post_abort_idle", {31'b0, resp_valid_o}, 32'd0);
        end
        pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01;
        run_txn(0, 1'b0, 1'b0, 0);

        // challenge and req_valid_i churn during evaluation
        pat[0] = 2'b10; pat[1] = 2'b00; pat[2] = 2'b01;
        run_txn(2, 1'b0, 1'b1, 0);

        // ready held high before valid rises
        pat[0] = 2'b11; pat[1] = 2'b01; pat[2] = 2'b00;
        run_txn(0, 1'b1, 1'b0, 0);

        for (int t = 0; t < 30; t++) begin
            for (int v = 0; v < V; v++) pat[v] = K'($urandom);
            run_txn(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
